// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU ops, forwards from EX/WB and registers operands for the ALU.
// Optional performance counters are compiled in when IDEX_PERF_CNT_EN is defined.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [XLEN-1:0]       ex_result,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_data1,
  output logic [XLEN-1:0]       ex_data2,
  output logic [3:0]            ex_alu_opcode,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_illegal
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_fwd_cnt
`endif
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [REG_ADDR_W-1:0] X0 = {REG_ADDR_W{1'b0}};

  logic [6:0]            f7_s;
  logic [2:0]            f3_s;
  logic [REG_ADDR_W-1:0] rs1_s, rs2_s, rd_s;
  logic [3:0]            dec_op_s;
  logic                  dec_is_r_s, dec_legal_s;
  logic                  rs1_ex_hit_s, rs1_wb_hit_s, rs2_ex_hit_s, rs2_wb_hit_s;
  logic [XLEN-1:0]       rs1_val_s, rs2_val_s, imm_s, op2_s;

  logic                  ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]       ex_data1_q, ex_data1_d, ex_data2_q, ex_data2_d;
  logic [3:0]            ex_op_q, ex_op_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_rw_q, ex_rw_d, ex_ill_q, ex_ill_d;

  assign f7_s  = id_instr[31:25];
  assign f3_s  = id_instr[14:12];
  assign rs1_s = id_instr[15 +: REG_ADDR_W];
  assign rs2_s = id_instr[20 +: REG_ADDR_W];
  assign rd_s  = id_instr[7 +: REG_ADDR_W];
  assign imm_s = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};

  // A legal encoding is exactly one that maps to a nonzero ALU opcode.
  always_comb begin
    dec_op_s   = 4'b0000;
    dec_is_r_s = 1'b0;
    case (id_instr[6:0])
      OPC_R: begin
        dec_is_r_s = 1'b1;
        case (f3_s)
          3'b000: begin
            if (f7_s == 7'b0000000)      dec_op_s = 4'b0001;
            else if (f7_s == 7'b0100000) dec_op_s = 4'b0010;
            else                         dec_op_s = 4'b0000;
          end
          3'b111:  dec_op_s = (f7_s == 7'b0000000) ? 4'b0011 : 4'b0000;
          3'b110:  dec_op_s = (f7_s == 7'b0000000) ? 4'b0100 : 4'b0000;
          3'b100:  dec_op_s = (f7_s == 7'b0000000) ? 4'b0101 : 4'b0000;
          default: dec_op_s = 4'b0000;
        endcase
      end
      OPC_I: begin
        case (f3_s)
          3'b000:  dec_op_s = 4'b0001;
          3'b111:  dec_op_s = 4'b0011;
          3'b110:  dec_op_s = 4'b0100;
          3'b100:  dec_op_s = 4'b0101;
          default: dec_op_s = 4'b0000;
        endcase
      end
      default: dec_op_s = 4'b0000;
    endcase
  end

  assign dec_legal_s = (dec_op_s != 4'b0000);

  function automatic logic [XLEN-1:0] fwd_pick(input logic is_x0, input logic ex_hit,
                                               input logic wb_hit, input logic [XLEN-1:0] ex_v,
                                               input logic [XLEN-1:0] wb_v, input logic [XLEN-1:0] rf_v);
    if (is_x0)       return {XLEN{1'b0}};
    else if (ex_hit) return ex_v;
    else if (wb_hit) return wb_v;
    else             return rf_v;
  endfunction

  assign rs1_ex_hit_s = ex_valid_q & ex_rw_q & (ex_rd_q == rs1_s) & (rs1_s != X0);
  assign rs1_wb_hit_s = wb_we & (wb_rd == rs1_s) & (rs1_s != X0);
  assign rs2_ex_hit_s = ex_valid_q & ex_rw_q & (ex_rd_q == rs2_s) & (rs2_s != X0);
  assign rs2_wb_hit_s = wb_we & (wb_rd == rs2_s) & (rs2_s != X0);

  assign rs1_val_s = fwd_pick(rs1_s == X0, rs1_ex_hit_s, rs1_wb_hit_s, ex_result, wb_data, id_rs1_data);
  assign rs2_val_s = fwd_pick(rs2_s == X0, rs2_ex_hit_s, rs2_wb_hit_s, ex_result, wb_data, id_rs2_data);
  assign op2_s     = dec_is_r_s ? rs2_val_s : imm_s;

  // Flush beats stall; a held stage never re-samples forwarding sources.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_data1_d = ex_data1_q;
    ex_data2_d = ex_data2_q;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_rw_d    = ex_rw_q;
    ex_ill_d   = ex_ill_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_rw_d    = 1'b0;
      ex_ill_d   = 1'b0;
    end else if (stall) begin
      ex_valid_d = ex_valid_q;
    end else begin
      ex_valid_d = id_valid;
      ex_data1_d = rs1_val_s;
      ex_data2_d = op2_s;
      ex_op_d    = dec_op_s;
      ex_rd_d    = rd_s;
      ex_rw_d    = id_valid & dec_legal_s & (rd_s != X0);
      ex_ill_d   = id_valid & ~dec_legal_s;
    end
  end

  // EX pipeline register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_data1_q <= {XLEN{1'b0}};
      ex_data2_q <= {XLEN{1'b0}};
      ex_op_q    <= 4'b0000;
      ex_rd_q    <= X0;
      ex_rw_q    <= 1'b0;
      ex_ill_q   <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_data1_q <= ex_data1_d;
      ex_data2_q <= ex_data2_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_rw_q    <= ex_rw_d;
      ex_ill_q   <= ex_ill_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_data1      = ex_data1_q;
  assign ex_data2      = ex_data2_q;
  assign ex_alu_opcode = ex_op_q;
  assign ex_rd         = ex_rd_q;
  assign ex_reg_write  = ex_rw_q;
  assign ex_illegal    = ex_ill_q;

`ifdef IDEX_PERF_CNT_EN
  logic        fwd_used_s, load_s;
  logic [31:0] perf_stall_q, perf_stall_d, perf_fwd_q, perf_fwd_d;

  assign load_s     = ~flush & ~stall & id_valid;
  assign fwd_used_s = dec_legal_s & ((rs1_ex_hit_s | rs1_wb_hit_s) |
                                     (dec_is_r_s & (rs2_ex_hit_s | rs2_wb_hit_s)));
  assign perf_stall_d = perf_stall_q + {31'd0, stall & ex_valid_q};
  assign perf_fwd_d   = perf_fwd_q + {31'd0, load_s & fwd_used_s};

  // Free-running counters; natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_fwd_q   <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_fwd_q   <= perf_fwd_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_fwd_cnt   = perf_fwd_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: decode, forwarding, stall/flush, illegal and reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, stall, flush, wb_we;
  logic [31:0] id_instr, id_rs1_data, id_rs2_data, ex_result, wb_data;
  logic [4:0]  wb_rd;
  logic        ex_valid, ex_reg_write, ex_illegal;
  logic [31:0] ex_data1, ex_data2;
  logic [3:0]  ex_alu_opcode;
  logic [4:0]  ex_rd;

  int checks = 0;
  int failures = 0;

  logic [75:0] obs, e;
  logic [2:0]  ctl, ectl;

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .stall(stall), .flush(flush),
    .ex_result(ex_result), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_data1(ex_data1), .ex_data2(ex_data2),
    .ex_alu_opcode(ex_alu_opcode), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  assign obs = {ex_valid, ex_data1, ex_data2, ex_alu_opcode, ex_rd, ex_reg_write, ex_illegal};
  assign ctl = {ex_valid, ex_reg_write, ex_illegal};

  function automatic logic [75:0] ev(input logic v, input logic [31:0] d1, input logic [31:0] d2,
                                     input logic [3:0] op, input logic [4:0] rd, input logic rw,
                                     input logic ill);
    return {v, d1, d2, op, rd, rw, ill};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; ex_result = 32'd0;
    id_instr = rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    id_rs1_data = 32'd5; id_rs2_data = 32'd7;
    for (int i = 0; i < 2; i++) begin
      step();
      e = ev(1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL reset%0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_add();
    rst_n = 1'b1;
    step();
    e = ev(1'b1, 32'd5, 32'd7, 4'b0001, 5'd3, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL add: got %h expected %h", obs, e); end
    checks++;
    if ((ex_data1 + ex_data2) !== 32'd12) begin
      failures++; $display("FAIL add_sum: got %h expected %h", ex_data1 + ex_data2, 32'd12);
    end
  endtask

  task automatic test_addi();
    id_instr = itype(12'hFFF, 5'd0, 3'b000, 5'd4);
    id_rs1_data = 32'h0000_1234; id_rs2_data = 32'h0000_AAAA;
    step();
    e = ev(1'b1, 32'd0, 32'hFFFF_FFFF, 4'b0001, 5'd4, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL addi_neg: got %h expected %h", obs, e); end
  endtask

  task automatic test_ops();
    logic [31:0] ins [7];
    logic [31:0] d2 [7];
    logic [3:0]  op [7];
    ins[0] = rtype(7'b0000000, 5'd11, 5'd10, 3'b111, 5'd12); d2[0] = 32'h0000_0F0F;  op[0] = 4'b0011;
    ins[1] = rtype(7'b0000000, 5'd11, 5'd10, 3'b110, 5'd12); d2[1] = 32'h0000_0F0F;  op[1] = 4'b0100;
    ins[2] = rtype(7'b0000000, 5'd11, 5'd10, 3'b100, 5'd12); d2[2] = 32'h0000_0F0F;  op[2] = 4'b0101;
    ins[3] = rtype(7'b0100000, 5'd11, 5'd10, 3'b000, 5'd12); d2[3] = 32'h0000_0F0F;  op[3] = 4'b0010;
    ins[4] = itype(12'h7FF, 5'd10, 3'b111, 5'd12);           d2[4] = 32'h0000_07FF;  op[4] = 4'b0011;
    ins[5] = itype(12'h800, 5'd10, 3'b110, 5'd12);           d2[5] = 32'hFFFF_F800;  op[5] = 4'b0100;
    ins[6] = itype(12'h7FF, 5'd10, 3'b100, 5'd12);           d2[6] = 32'h0000_07FF;  op[6] = 4'b0101;
    id_rs1_data = 32'hF0F0_0000; id_rs2_data = 32'h0000_0F0F;
    for (int i = 0; i < 7; i++) begin
      id_instr = ins[i];
      step();
      e = ev(1'b1, 32'hF0F0_0000, d2[i], op[i], 5'd12, 1'b1, 1'b0);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL ops%0d: got %h expected %h", i, obs, e); end
    end
  endtask

  task automatic test_back_to_back();
    id_instr = rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    id_rs1_data = 32'd1; id_rs2_data = 32'd2;
    step();
    e = ev(1'b1, 32'd1, 32'd2, 4'b0001, 5'd3, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_prod: got %h expected %h", obs, e); end
    // sub x5,x3,x1 : EX (0x10) beats WB (0x99)
    id_instr = rtype(7'b0100000, 5'd1, 5'd3, 3'b000, 5'd5);
    id_rs1_data = 32'h55; id_rs2_data = 32'h22;
    ex_result = 32'h10; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h99;
    step();
    e = ev(1'b1, 32'h10, 32'h22, 4'b0010, 5'd5, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL fwd_ex_over_wb: got %h expected %h", obs, e); end
    // add x8,x3,x5 : rs1 from WB, rs2 from EX
    id_instr = rtype(7'b0000000, 5'd5, 5'd3, 3'b000, 5'd8);
    ex_result = 32'h20;
    step();
    e = ev(1'b1, 32'h99, 32'h20, 4'b0001, 5'd8, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL fwd_wb_rs1_ex_rs2: got %h expected %h", obs, e); end
    // addi x9,x1,8 : imm field aliases rs2=x8 (in EX) but must stay immediate
    id_instr = itype(12'h008, 5'd1, 3'b000, 5'd9);
    ex_result = 32'h30;
    step();
    e = ev(1'b1, 32'h55, 32'h8, 4'b0001, 5'd9, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL itype_no_rs2_fwd: got %h expected %h", obs, e); end
    // add x0,x1,x2 : rd=0 never writes
    id_instr = rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0);
    step();
    e = ev(1'b1, 32'h55, 32'h22, 4'b0001, 5'd0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL rd0_no_write: got %h expected %h", obs, e); end
    // sub x5,x0,x1 : x0 reads as 0 despite regfile and WB to x0
    id_instr = rtype(7'b0100000, 5'd1, 5'd0, 3'b000, 5'd5);
    ex_result = 32'h10; wb_rd = 5'd0; wb_data = 32'h99;
    step();
    e = ev(1'b1, 32'h0, 32'h22, 4'b0010, 5'd5, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL x0_no_fwd: got %h expected %h", obs, e); end
    wb_we = 1'b0;
  endtask

  task automatic test_stall_flush();
    id_instr = rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    id_rs1_data = 32'd5; id_rs2_data = 32'd7;
    step();
    e = ev(1'b1, 32'd5, 32'd7, 4'b0001, 5'd3, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL stall_load: got %h expected %h", obs, e); end
    stall = 1'b1;
    id_instr = rtype(7'b0100000, 5'd3, 5'd3, 3'b000, 5'd6);
    id_rs1_data = 32'hDEAD; id_rs2_data = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      ex_result = 32'h100 + i;
      step();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, e); end
    end
    flush = 1'b1;
    step();
    ectl = 3'b000;
    checks++;
    if (ctl !== ectl) begin failures++; $display("FAIL flush_over_stall: got %b expected %b", ctl, ectl); end
    flush = 1'b0; stall = 1'b0; id_valid = 1'b0;
    id_instr = rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    step();
    checks++;
    if (ctl !== ectl) begin failures++; $display("FAIL bubble: got %b expected %b", ctl, ectl); end
  endtask

  task automatic test_illegal();
    logic [7:0] got, exp;
    id_valid = 1'b1; id_instr = 32'h0000_707F;
    step();
    got = {ex_valid, ex_alu_opcode, ex_reg_write, ex_illegal, 1'b0};
    exp = {1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL illegal_word: got %b expected %b", got, exp); end
    id_valid = 1'b0;
    step();
    ectl = 3'b000;
    checks++;
    if (ctl !== ectl) begin failures++; $display("FAIL illegal_bubble: got %b expected %b", ctl, ectl); end
    id_valid = 1'b1; id_instr = rtype(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3);
    step();
    got = {ex_valid, ex_alu_opcode, ex_reg_write, ex_illegal, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL bad_funct7: got %b expected %b", got, exp); end
    id_instr = itype(12'h001, 5'd1, 3'b001, 5'd3);
    step();
    got = {ex_valid, ex_alu_opcode, ex_reg_write, ex_illegal, 1'b0};
    checks++;
    if (got !== exp) begin failures++; $display("FAIL bad_funct3: got %b expected %b", got, exp); end
  endtask

  task automatic test_reset_mid();
    id_instr = rtype(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    id_rs1_data = 32'd5; id_rs2_data = 32'd7;
    step();
    stall = 1'b1; flush = 1'b1; rst_n = 1'b0;
    step();
    e = ev(1'b0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_mid_stall: got %h expected %h", obs, e); end
    stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
    step();
    e = ev(1'b1, 32'd5, 32'd7, 4'b0001, 5'd3, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_release_load: got %h expected %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_ops();
    test_back_to_back();
    test_stall_flush();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU.
- Each cycle it decodes the instruction in ID into a 4-bit ALU opcode and selects operands, including the sign-extended immediate.
- It resolves RAW hazards by forwarding from the EX result and the WB write port, then registers everything for the EX stage.
- Registered outputs drive the ALU's Data1, Data2 and alu_opcode inputs; the ALU result returns as ex_result for forwarding.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- id_valid  input  1  ID holds a valid instruction
- id_instr  input  32  raw instruction word
- id_rs1_data  input  XLEN  regfile read of rs1
- id_rs2_data  input  XLEN  regfile read of rs2
- stall  input  1  hold EX register contents
- flush  input  1  kill instruction entering EX
- ex_result  input  XLEN  ALU output of instruction currently in EX
- wb_we  input  1  WB register write enable
- wb_rd  input  REG_ADDR_W  WB destination
- wb_data  input  XLEN  WB write data
- ex_valid  output  1  EX register holds a valid instruction
- ex_data1  output  XLEN  ALU operand 1
- ex_data2  output  XLEN  ALU operand 2
- ex_alu_opcode  output  4  ALU opcode
- ex_rd  output  REG_ADDR_W  destination register
- ex_reg_write  output  1  instruction writes rd
- ex_illegal  output  1  unsupported encoding captured

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. While rst_n=0 at a rising edge, all outputs clear to 0.
- Decode, R-type (opcode 0110011):
  - funct3 000 with funct7=0000000 -> 0001 (add); with funct7=0100000 -> 0010 (sub).
  - funct3 111 -> 0011 (and); 110 -> 0100 (or); 100 -> 0101 (xor).
  - Operand 2 = rs2 value.
- Decode, I-type (opcode 0010011):
  - funct3 000 -> 0001 (addi); 111 -> 0011; 110 -> 0100; 100 -> 0101.
  - Operand 2 = sign-extended instr[31:20].
- Decode, anything else (other opcode, funct3 or funct7): opcode 0000, reg_write=0, illegal=1. The ALU then yields 0.
- reg_write = 1 only for legal R/I encodings with rd != 0.
- Forwarding, evaluated combinationally on the ID-side operands for rs1 (instr[19:15]) and rs2 (instr[24:20], R-type only). Priority order:
  1. ex_valid & ex_reg_write & ex_rd==rs & rs!=0 -> ex_result.
  2. wb_we & wb_rd==rs & rs!=0 -> wb_data.
  3. Otherwise regfile data.
- rs==0 always yields 0, regardless of regfile or forward sources.
- Register update priority per rising edge, with rst_n=1:
  1. flush=1: ex_valid=0, ex_reg_write=0, ex_illegal=0. Data fields don't-care but must not propagate writes. Flush wins over stall.
  2. stall=1: all EX registers hold. No forwarding re-evaluation of held operands.
  3. Else: load decoded/forwarded values. ex_valid=id_valid. reg_write and illegal are gated by id_valid.
- Latency: exactly 1 cycle ID->EX. Throughput 1 instruction/cycle when not stalled.
- An invalid (bubble) instruction never asserts ex_reg_write or ex_illegal.
- Reset asserted mid-stall or mid-flush: reset wins and all outputs go to 0.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- When defined, adds output ports:
  - perf_stall_cnt (32): counts edges with stall=1 & ex_valid=1.
  - perf_fwd_cnt (32): counts loaded instructions that used at least one forwarded operand.
- Both counters reset to 0 and wrap at 2^32-1 -> 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 -> all outputs 0. First edge after release loads normally.
- add x3,x1,x2 with rs1_data=5, rs2_data=7 -> next cycle ex_data1=5, ex_data2=7, opcode=0001, ex_rd=3, reg_write=1; ALU gives 12.
- addi x4,x0,-1 -> ex_data1=0, ex_data2=0xFFFFFFFF, opcode=0001.
- Back-to-back: sub x5,x3,x1 following an instruction in EX with rd=3, ex_result=0x10, while wb_rd=3, wb_data=0x99 -> ex_data1=0x10 (EX beats WB). Repeat with rd=0 as destination -> no forwarding.
- stall=1 for 3 cycles, then flush=1 together with stall=1 -> outputs hold during stall; ex_valid=0 after the flush edge.
- Illegal word 0x0000707F -> ex_opcode=0000, ex_illegal=1, reg_write=0. Same word with id_valid=0 -> ex_illegal=0.
